// File: rtl/wb_main_mem.sv
// Wishbone main memory: 128-bit line storage behind a 32- or 128-bit slave port,
// with optional address wrap, range error and a configurable read latency.
module wb_main_mem #(
  parameter int WB_DWIDTH      = 32,
  parameter int MEM_BYTES_LOG2 = 27,
  parameter int WRAP_LOG2      = 25,
  parameter int RD_LATENCY     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_mem_ctrl,
  input  logic [31:0]            i_wb_adr,
  input  logic [WB_DWIDTH/8-1:0] i_wb_sel,
  input  logic                   i_wb_we,
  input  logic [WB_DWIDTH-1:0]   i_wb_dat,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  output logic [WB_DWIDTH-1:0]   o_wb_dat,
  output logic                   o_wb_ack,
  output logic                   o_wb_err
);

  localparam int IDXW  = MEM_BYTES_LOG2 - 4;
  localparam int LINES = 2 ** IDXW;
  localparam logic [MEM_BYTES_LOG2-1:0] WRAP_MASK =
    {MEM_BYTES_LOG2{1'b1}} >> (MEM_BYTES_LOG2 - WRAP_LOG2);
  localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    TERM      = 2'd2
  } state_t;

  logic [127:0] mem_r [LINES];

  state_t                  state_r, state_nxt_s;
  logic [2:0]              cnt_r, cnt_nxt_s;
  logic [IDXW-1:0]         idx_r, idx_nxt_s;
  logic [1:0]              lane_r, lane_nxt_s;
  logic                    ack_r, ack_nxt_s;
  logic                    err_r, err_nxt_s;
  logic [WB_DWIDTH-1:0]    dat_r, dat_nxt_s;

  logic [MEM_BYTES_LOG2-1:0] eff_adr_s;
  logic                      range_err_s;
  logic [IDXW-1:0]           idx_s, rd_idx_s;
  logic [1:0]                lane_s, rd_lane_s;
  logic                      req_s, mem_we_s;
  logic [127:0]              wr_data_s, wr_bmask_s, rd_line_s;
  logic [15:0]               wr_be_s;
  logic [WB_DWIDTH-1:0]      rd_word_s;
  logic                      unused_s;

  // Address decode: wrap window masking and out-of-range detection.
  always_comb begin
    if (i_mem_ctrl) begin
      eff_adr_s   = i_wb_adr[MEM_BYTES_LOG2-1:0] & WRAP_MASK;
      range_err_s = 1'b0;
    end else begin
      eff_adr_s   = i_wb_adr[MEM_BYTES_LOG2-1:0];
      range_err_s = |i_wb_adr[31:MEM_BYTES_LOG2];
    end
  end

  assign idx_s  = eff_adr_s[MEM_BYTES_LOG2-1:4];
  assign lane_s = eff_adr_s[3:2];
  assign req_s  = i_wb_cyc & i_wb_stb;

  // Single-cycle reads (RD_LATENCY=1) read the line addressed by the live request.
  assign rd_idx_s  = (state_r == IDLE) ? idx_s  : idx_r;
  assign rd_lane_s = (state_r == IDLE) ? lane_s : lane_r;
  assign rd_line_s = mem_r[rd_idx_s];

  generate
    if (WB_DWIDTH == 32) begin : g_w32
      assign wr_data_s = {4{i_wb_dat}};
      assign wr_be_s   = 16'(i_wb_sel) << {lane_s, 2'b00};
      assign rd_word_s = rd_line_s[{rd_lane_s, 5'd0} +: 32];
    end else begin : g_w128
      assign wr_data_s = i_wb_dat;
      assign wr_be_s   = i_wb_sel;
      assign rd_word_s = rd_line_s;
    end
  endgenerate

  // Expand byte enables into a per-bit write mask for the line.
  always_comb begin
    wr_bmask_s = 128'd0;
    for (int i = 0; i < 16; i++) begin
      wr_bmask_s[8*i +: 8] = {8{wr_be_s[i]}};
    end
  end

  // Next-state and output decode for the request FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    lane_nxt_s  = lane_r;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    dat_nxt_s   = dat_r;
    mem_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (range_err_s) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = TERM;
          end else if (i_wb_we) begin
            mem_we_s    = 1'b1;
            ack_nxt_s   = 1'b1;
            state_nxt_s = TERM;
          end else begin
            idx_nxt_s  = idx_s;
            lane_nxt_s = lane_s;
            if (RD_LATENCY == 1) begin
              cnt_nxt_s   = 3'd0;
              dat_nxt_s   = rd_word_s;
              ack_nxt_s   = 1'b1;
              state_nxt_s = TERM;
            end else begin
              cnt_nxt_s   = CNT_LOAD;
              state_nxt_s = READ_WAIT;
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (!i_wb_cyc) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = IDLE;
        end else if (cnt_r <= 3'd1) begin
          cnt_nxt_s   = 3'd0;
          dat_nxt_s   = rd_word_s;
          ack_nxt_s   = 1'b1;
          state_nxt_s = TERM;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      TERM: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      idx_r   <= '0;
      lane_r  <= 2'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      lane_r  <= lane_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      dat_r   <= dat_nxt_s;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= (mem_r[idx_s] & ~wr_bmask_s) | (wr_data_s & wr_bmask_s);
    end
  end

  assign o_wb_dat = dat_r;
  assign o_wb_ack = ack_r;
  assign o_wb_err = err_r;
  assign unused_s = ^{eff_adr_s[1:0], rd_lane_s, lane_r};

endmodule

// File: tb/tb_wb_main_mem.sv
// Bench for wb_main_mem: a default 32-bit instance, a small 128-bit RD_LATENCY=1
// instance and a small 32-bit RD_LATENCY=4 instance share one bus.
module tb_wb_main_mem;

  logic         clk;
  logic         rst_n;
  int           tgt;
  logic         b_ctrl, b_we, b_cyc, b_stb;
  logic [31:0]  b_adr;
  logic [15:0]  b_sel;
  logic [127:0] b_dat;

  logic [31:0]  dout0, dout2;
  logic [127:0] dout1;
  logic         ack0, err0, ack1, err1, ack2, err2;
  logic         m_ack, m_err;
  logic [127:0] m_dout;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic         we;
    logic         ctrl;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] wd;
    logic         err;
    logic [127:0] dat;
    int           lat;
  } vec_t;

  typedef struct {
    string        nm;
    logic         err;
    logic [127:0] dat;
    int           lat;
  } exp_t;

  vec_t tbl[16];
  exp_t sb_q[$];

  wb_main_mem u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_ctrl(b_ctrl), .i_wb_adr(b_adr),
    .i_wb_sel(b_sel[3:0]), .i_wb_we(b_we), .i_wb_dat(b_dat[31:0]),
    .i_wb_cyc(b_cyc & (tgt == 0)), .i_wb_stb(b_stb & (tgt == 0)),
    .o_wb_dat(dout0), .o_wb_ack(ack0), .o_wb_err(err0)
  );

  wb_main_mem #(.WB_DWIDTH(128), .MEM_BYTES_LOG2(12), .WRAP_LOG2(8), .RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_ctrl(b_ctrl), .i_wb_adr(b_adr),
    .i_wb_sel(b_sel), .i_wb_we(b_we), .i_wb_dat(b_dat),
    .i_wb_cyc(b_cyc & (tgt == 1)), .i_wb_stb(b_stb & (tgt == 1)),
    .o_wb_dat(dout1), .o_wb_ack(ack1), .o_wb_err(err1)
  );

  wb_main_mem #(.WB_DWIDTH(32), .MEM_BYTES_LOG2(12), .WRAP_LOG2(8), .RD_LATENCY(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_ctrl(b_ctrl), .i_wb_adr(b_adr),
    .i_wb_sel(b_sel[3:0]), .i_wb_we(b_we), .i_wb_dat(b_dat[31:0]),
    .i_wb_cyc(b_cyc & (tgt == 2)), .i_wb_stb(b_stb & (tgt == 2)),
    .o_wb_dat(dout2), .o_wb_ack(ack2), .o_wb_err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    m_ack  = ack0;
    m_err  = err0;
    m_dout = {96'd0, dout0};
    if (tgt == 1) begin
      m_ack  = ack1;
      m_err  = err1;
      m_dout = dout1;
    end else if (tgt == 2) begin
      m_ack  = ack2;
      m_err  = err2;
      m_dout = {96'd0, dout2};
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // One transaction: expectation queued at drive time, popped when the DUT terminates.
  task automatic xfer(input int t, input logic we, input logic ctrl, input logic [31:0] adr,
                      input logic [15:0] sel, input logic [127:0] wd, input logic e_err,
                      input logic [127:0] e_dat, input int e_lat, input string nm);
    exp_t e;
    int   n;
    logic seen;
    @(posedge clk); #1;
    tgt = t; b_we = we; b_ctrl = ctrl; b_adr = adr; b_sel = sel; b_dat = wd;
    b_cyc = 1'b1; b_stb = 1'b1;
    sb_q.push_back('{nm, e_err, e_dat, e_lat});
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      @(negedge clk);
      n++;
      seen = m_ack | m_err;
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    e = sb_q.pop_front();
    chk({e.nm, " latency"}, 128'(n), 128'(e.lat));
    chk({e.nm, " err"}, 128'(m_err), 128'(e.err));
    chk({e.nm, " ack"}, 128'(m_ack), 128'(!e.err));
    chk({e.nm, " data"}, m_dout, e.dat);
    @(negedge clk);
    chk({e.nm, " pulse"}, 128'({m_ack, m_err}), 128'd0);
  endtask

  initial begin
    logic any_s;
    tgt = 0; b_ctrl = 1'b0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
    b_adr = 32'd0; b_sel = 16'd0; b_dat = 128'd0;
    rst_n = 1'b1;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0104, 16'hF, 128'hAABBCCDD, 1'b0, 128'h0,        1};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0104, 16'h5, 128'h11223344, 1'b0, 128'h0,        1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0000_0104, 16'h0, 128'h0,        1'b0, 128'hAA22CC44, 2};
    tbl[3]  = '{1'b1, 1'b1, 32'h0200_0010, 16'hF, 128'hDEADBEEF, 1'b0, 128'hAA22CC44, 1};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0010, 16'h0, 128'h0,        1'b0, 128'hDEADBEEF, 2};
    tbl[5]  = '{1'b0, 1'b0, 32'h0000_0010, 16'h0, 128'h0,        1'b0, 128'hDEADBEEF, 2};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0000, 16'hF, 128'h5A5A5A5A, 1'b0, 128'hDEADBEEF, 1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0800_0000, 16'h0, 128'h0,        1'b1, 128'hDEADBEEF, 1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0800_0000, 16'hF, 128'hFFFFFFFF, 1'b1, 128'hDEADBEEF, 1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0000_0000, 16'h0, 128'h0,        1'b0, 128'h5A5A5A5A, 2};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0108, 16'hF, 128'hCAFEF00D, 1'b0, 128'h5A5A5A5A, 1};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0108, 16'h0, 128'h12345678, 1'b0, 128'h5A5A5A5A, 1};
    tbl[12] = '{1'b0, 1'b0, 32'h0000_0108, 16'h0, 128'h0,        1'b0, 128'hCAFEF00D, 2};
    tbl[13] = '{1'b0, 1'b1, 32'hFE00_0104, 16'h0, 128'h0,        1'b0, 128'hAA22CC44, 2};
    tbl[14] = '{1'b1, 1'b0, 32'h07FF_FFFC, 16'hF, 128'h0BADC0DE, 1'b0, 128'hAA22CC44, 1};
    tbl[15] = '{1'b0, 1'b0, 32'h07FF_FFFC, 16'h0, 128'h0,        1'b0, 128'h0BADC0DE, 2};

    #2 rst_n = 1'b0;
    #1;
    chk("reset ack0", 128'(ack0), 128'd0);
    chk("reset err0", 128'(err0), 128'd0);
    chk("reset dat0", 128'(dout0), 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      xfer(0, tbl[i].we, tbl[i].ctrl, tbl[i].adr, tbl[i].sel, tbl[i].wd,
           tbl[i].err, tbl[i].dat, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // 128-bit instance, single-cycle read latency.
    xfer(1, 1'b1, 1'b0, 32'h40, 16'hFFFF, 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F,
         1'b0, 128'h0, 1, "w128 full");
    xfer(1, 1'b1, 1'b0, 32'h40, 16'h00FF, 128'h00112233_44556677_8899AABB_CCDDEEFF,
         1'b0, 128'h0, 1, "w128 low");
    xfer(1, 1'b0, 1'b0, 32'h40, 16'h0, 128'h0,
         1'b0, 128'hF0E1D2C3_B4A59687_8899AABB_CCDDEEFF, 1, "r128");
    xfer(1, 1'b0, 1'b1, 32'h140, 16'h0, 128'h0,
         1'b0, 128'hF0E1D2C3_B4A59687_8899AABB_CCDDEEFF, 1, "r128 wrap");
    xfer(1, 1'b0, 1'b0, 32'h1000, 16'h0, 128'h0,
         1'b1, 128'hF0E1D2C3_B4A59687_8899AABB_CCDDEEFF, 1, "r128 err");

    // Latency-4 instance with a read aborted by dropping cyc.
    xfer(2, 1'b1, 1'b0, 32'h20, 16'hF, 128'h600DF00D, 1'b0, 128'h0, 1, "l4 w20");
    xfer(2, 1'b0, 1'b0, 32'h20, 16'h0, 128'h0, 1'b0, 128'h600DF00D, 4, "l4 r20");
    xfer(2, 1'b1, 1'b0, 32'h24, 16'hF, 128'h77778888, 1'b0, 128'h600DF00D, 1, "l4 w24");
    @(posedge clk); #1;
    tgt = 2; b_we = 1'b0; b_ctrl = 1'b0; b_adr = 32'h24; b_cyc = 1'b1; b_stb = 1'b1;
    @(posedge clk); #1;
    b_cyc = 1'b0; b_stb = 1'b0;
    any_s = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_s = any_s | ack2 | err2;
    end
    chk("abort no ack", 128'(any_s), 128'd0);
    chk("abort dat", 128'(dout2), 128'h600DF00D);
    xfer(2, 1'b0, 1'b0, 32'h24, 16'h0, 128'h0, 1'b0, 128'h77778888, 4, "l4 r24");

    // Reset asserted while a read is waiting.
    @(posedge clk); #1;
    tgt = 0; b_we = 1'b0; b_ctrl = 1'b0; b_adr = 32'h104; b_cyc = 1'b1; b_stb = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst ack", 128'(ack0), 128'd0);
    chk("rst err", 128'(err0), 128'd0);
    chk("rst dat", 128'(dout0), 128'd0);
    b_cyc = 1'b0; b_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    any_s = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_s = any_s | ack0 | err0;
    end
    chk("rst no ack", 128'(any_s), 128'd0);

    // Request already present when reset releases is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b0;
    b_we = 1'b1; b_adr = 32'h200; b_sel = 16'hF; b_dat = 128'h13579BDF;
    b_cyc = 1'b1; b_stb = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first edge ack", 128'(ack0), 128'd1);
    b_cyc = 1'b0; b_stb = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, 1'b0, 32'h200, 16'h0, 128'h0, 1'b0, 128'h13579BDF, 2, "post rst r200");
    xfer(0, 1'b0, 1'b0, 32'h104, 16'h0, 128'h0, 1'b0, 128'hAA22CC44, 2, "kept r104");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_main_mem.md
WB_MAIN_MEM -- requirements
Module: wb_main_mem

Interface
REQ-001 SHALL have parameter WB_DWIDTH, default 32, meaning Wishbone data width (legal values 32 or 128).
REQ-002 SHALL have parameter MEM_BYTES_LOG2, default 27, meaning log2 of storage size in bytes (128 MB).
REQ-003 SHALL have parameter WRAP_LOG2, default 25, meaning log2 of the wrap window in bytes when i_mem_ctrl=1 (32 MB); legal range 4..MEM_BYTES_LOG2.
REQ-004 SHALL have parameter RD_LATENCY, default 2, meaning cycles from read acceptance to ack (legal range 1..7).
REQ-005 SHALL have i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have i_mem_ctrl  input  1  address mode: 0 = full size with range check, 1 = wrap at 2^WRAP_LOG2.
REQ-008 SHALL have i_wb_adr  input  32  byte address.
REQ-009 SHALL have i_wb_sel  input  WB_DWIDTH/8  byte enables.
REQ-010 SHALL have i_wb_we  input  1  1 = write.
REQ-011 SHALL have i_wb_dat  input  WB_DWIDTH  write data.
REQ-012 SHALL have i_wb_cyc, i_wb_stb  input  1 each  cycle/strobe.
REQ-013 SHALL have o_wb_dat  output  WB_DWIDTH  registered read data.
REQ-014 SHALL have o_wb_ack, o_wb_err  output  1 each  registered single-cycle termination pulses.

Function
REQ-015 Storage SHALL be 2^(MEM_BYTES_LOG2-4) lines of 128 bits; line index = effective address bits [MEM_BYTES_LOG2-1:4].
REQ-016 Effective address SHALL be i_wb_adr[WRAP_LOG2-1:0] zero-extended when i_mem_ctrl=1, else i_wb_adr[MEM_BYTES_LOG2-1:0].
REQ-017 FSM states SHALL be IDLE, READ_WAIT, TERM; reset state IDLE.
REQ-018 A request SHALL be accepted only in IDLE on a rising edge with i_wb_cyc=1 and i_wb_stb=1; requests in other states are ignored, and the master holds stb until termination.
REQ-019 Out of range (i_mem_ctrl=0 and i_wb_adr[31:MEM_BYTES_LOG2] non-zero) SHALL: no storage access, go to TERM, o_wb_err=1 for exactly the next cycle, o_wb_dat unchanged.
REQ-020 Write acceptance SHALL commit the write on the accepting edge: selected bytes replaced, unselected bytes of the line unchanged; then TERM with o_wb_ack=1 for exactly the next cycle.
REQ-021 In 32-bit mode the write SHALL target word lane i_wb_adr[3:2] of the line; in 128-bit mode i_wb_sel[i] SHALL enable line byte i.
REQ-022 A write with i_wb_sel all zero SHALL leave storage unchanged and still ack.
REQ-023 Read acceptance SHALL capture the line index and lane and load a down-counter with RD_LATENCY-1; with RD_LATENCY=1 it goes directly to TERM.
REQ-024 In READ_WAIT the counter SHALL decrement each cycle; at zero, o_wb_dat SHALL be loaded with the addressed word (32-bit: lane adr[3:2]; 128-bit: whole line) and o_wb_ack asserted on the same edge.
REQ-025 o_wb_ack SHALL therefore rise exactly RD_LATENCY cycles after the accepting edge for reads and 1 cycle after for writes and errors.
REQ-026 TERM SHALL last one cycle and return to IDLE; the earliest next acceptance is the edge ending TERM (one request per 2 cycles at RD_LATENCY=1).
REQ-027 Read data SHALL reflect all writes acknowledged before acceptance of the read.
REQ-028 i_wb_cyc=0 during READ_WAIT SHALL abort to IDLE: no ack, o_wb_dat unchanged.
REQ-029 o_wb_ack and o_wb_err SHALL never be asserted together and never for two consecutive cycles.
REQ-030 o_wb_dat SHALL hold its value except on a read completion.

Reset
REQ-031 i_rst_n=0 SHALL immediately force o_wb_ack=0, o_wb_err=0, o_wb_dat=0, counter=0, state IDLE.
REQ-032 Reset SHALL not initialise or modify storage; a write committed before reset remains; an in-flight read is dropped without ack.
REQ-033 Requests SHALL be accepted from the first rising edge after i_rst_n deasserts.

Verification
REQ-034 Reset: i_rst_n low mid-READ_WAIT -> ack=0, err=0, o_wb_dat=0 immediately; no ack after release.
REQ-035 32-bit: 0x104 holds 0xAABBCCDD; write 0x11223344 sel=4'b0101 -> ack 1 cycle later; read 0x104 -> 0xAA22CC44 with ack exactly 2 cycles after acceptance.
REQ-036 Wrap: i_mem_ctrl=1, write 0xDEADBEEF to 0x02000010; read 0x00000010 -> 0xDEADBEEF.
REQ-037 Error: i_mem_ctrl=0, read/write 0x08000000 -> err one cycle, no ack, o_wb_dat and location 0x0 unchanged.
REQ-038 Abort: RD_LATENCY=4, read issued, i_wb_cyc dropped one cycle later -> no ack, o_wb_dat unchanged; following read acks in 4 cycles with correct data.
REQ-039 128-bit: write line 0x00112233_44556677_8899AABB_CCDDEEFF sel=16'h00FF to 0x40 -> read 0x40 returns upper 8 bytes unchanged, lower 8 bytes 0x8899AABBCCDDEEFF.
